// File: rtl/ad_cap_pkg.sv
// Shared types for the ADC capture controller: FSM state encoding, trigger
// mode encodings and a helper that folds the reserved mode onto immediate.
// No logic of its own; imported by ad_capture_ctrl and ad_cap_fifo.

package ad_cap_pkg;

    // Capture controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

    // Trigger mode encodings as seen on the trig_mode port.
    localparam logic [1:0] TRIG_IMM  = 2'b00;
    localparam logic [1:0] TRIG_RISE = 2'b01;
    localparam logic [1:0] TRIG_FALL = 2'b10;

    // FIFO entry layout: {last, otr, data}. Bit offsets relative to DATA_W.
    localparam int ENTRY_OTR_OFS  = 0;
    localparam int ENTRY_LAST_OFS = 1;

    // Mode 2'b11 is reserved and behaves exactly like immediate, so it is
    // folded at latch time and the rest of the controller never sees it.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == 2'b11) ? TRIG_IMM : mode;
    endfunction

endpackage

// File: rtl/ad_cap_fifo.sv
// Synchronous FIFO with a registered read port (first-word fall-through into rd_dat).
// Latency: a write into an empty FIFO shows rd_vld one cycle after the write edge.
// Backpressure: rd_dat/rd_vld hold while rd_rdy=0; writes while full are dropped.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   wr_vld, wr_dat   - write request and data (ignored when full)
//   full, empty      - occupancy flags; occupancy counts the output register
//   rd_vld, rd_rdy   - read handshake, transfer when both high
//   rd_dat           - registered read data

module ad_cap_fifo
    import ad_cap_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             empty,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_cnt;
    logic [AW:0]      occ;
    logic             wr_en;
    logic             mem_nonempty;
    logic             load_out;
    logic             mem_rd;

    // Total occupancy includes the output register so that DEPTH is the
    // true number of samples the buffer can hold. Full is evaluated before
    // any same-cycle read, so a write that coincides with a pop while full
    // is still dropped.
    assign occ          = mem_cnt + {{AW{1'b0}}, rd_vld};
    assign full         = (occ == (AW+1)'(DEPTH));
    assign empty        = (occ == '0);
    assign wr_en        = wr_vld && !full;
    assign mem_nonempty = (mem_cnt != '0);
    // Output register can accept a new word when it is empty or being popped.
    assign load_out     = !rd_vld || rd_rdy;
    assign mem_rd       = load_out && mem_nonempty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            rd_vld  <= 1'b0;
            rd_dat  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (mem_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, mem_rd})
                2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            if (load_out) begin
                rd_vld <= mem_nonempty;
                if (mem_nonempty) begin
                    rd_dat <= mem[rd_ptr];
                end
            end
        end
    end

endmodule

// File: rtl/ad_capture_ctrl.sv
// ADC frame capture: arm, wait for trigger, keep 1 of (decim+1) samples, buffer a frame.
// Latency: pin sample to FIFO write is 3 cycles; m_valid follows a write by 1 cycle.
// Backpressure: m_* hold while m_ready=0; a kept sample hitting a full FIFO aborts the frame and sets ovf.
//
// Ports:
//   clk, rst                 - ADC sample clock, synchronous active-high reset
//   ad_data, ad_otr          - raw ADC sample and out-of-range flag
//   arm                      - single-cycle capture request (honoured only in IDLE)
//   trig_mode, trig_level    - trigger selection and unsigned threshold (latched on arm)
//   decim                    - keep 1 of (decim+1) samples (latched on arm)
//   m_data, m_otr, m_last    - output sample, its OTR bit, end-of-frame marker
//   m_valid, m_ready         - output handshake
//   busy, ovf                - capture in progress, sticky overflow (cleared by arm)

module ad_capture_ctrl
    import ad_cap_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FRAME_LEN  = 1024,
    parameter int DECIM_W    = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_otr,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DECIM_W-1:0] decim,
    output logic [DATA_W-1:0] m_data,
    output logic              m_otr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              ovf
);

    localparam int FW = DATA_W + 2;

    // Input pipeline: s1 is the pin-side register, s2 feeds all decisions.
    logic [DATA_W-1:0]  s1_dat;
    logic               s1_otr;
    logic [DATA_W-1:0]  s2_dat;
    logic               s2_otr;
    logic [DATA_W-1:0]  s2_prev;

    // Controller state and values latched at arm time.
    cap_state_t         state;
    logic [1:0]         mode_q;
    logic [DATA_W-1:0]  level_q;
    logic [DECIM_W-1:0] decim_q;
    logic [DECIM_W-1:0] dcnt;
    logic [15:0]        fcnt;
    logic               ovf_q;

    // Datapath decisions.
    logic               rise_hit;
    logic               fall_hit;
    logic               trig_hit;
    logic               keep;
    logic               is_last;
    logic               drop;
    logic [DECIM_W-1:0] dcnt_next;

    // FIFO interface.
    logic               fifo_wr_vld;
    logic [FW-1:0]      fifo_wr_dat;
    logic               fifo_full;
    logic               fifo_empty_unused;
    logic [FW-1:0]      fifo_rd_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_dat  <= '0;
            s1_otr  <= 1'b0;
            s2_dat  <= '0;
            s2_otr  <= 1'b0;
            s2_prev <= '0;
        end else begin
            s1_dat  <= ad_data;
            s1_otr  <= ad_otr;
            s2_dat  <= s1_dat;
            s2_otr  <= s1_otr;
            s2_prev <= s2_dat;
        end
    end

    assign rise_hit = (s2_prev <  level_q) && (s2_dat >= level_q);
    assign fall_hit = (s2_prev >= level_q) && (s2_dat <  level_q);

    always_comb begin
        trig_hit = 1'b1;
        case (mode_q)
            TRIG_RISE: trig_hit = rise_hit;
            TRIG_FALL: trig_hit = fall_hit;
            default:   trig_hit = 1'b1;
        endcase
    end

    // The trigger sample is decimation slot 0: dcnt sits at 0 through ARMED,
    // so the same stepping rule covers the trigger cycle and CAPTURE.
    assign keep      = ((state == ST_ARMED) && trig_hit) ||
                       ((state == ST_CAPTURE) && (dcnt == '0));
    assign dcnt_next = (dcnt == decim_q) ? '0 : dcnt + DECIM_W'(1);
    assign is_last   = (fcnt == 16'(FRAME_LEN - 1));
    assign drop      = keep && fifo_full;

    assign fifo_wr_vld = keep && !fifo_full;
    assign fifo_wr_dat = {is_last, s2_otr, s2_dat};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mode_q  <= TRIG_IMM;
            level_q <= '0;
            decim_q <= '0;
            dcnt    <= '0;
            fcnt    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        mode_q  <= norm_mode(trig_mode);
                        level_q <= trig_level;
                        decim_q <= decim;
                        dcnt    <= '0;
                        fcnt    <= '0;
                        ovf_q   <= 1'b0;
                        state   <= ST_ARMED;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (state == ST_CAPTURE || keep) begin
                        dcnt <= dcnt_next;
                    end
                    if (drop) begin
                        // Frame aborted: nothing more is written, so no last marker.
                        ovf_q <= 1'b1;
                        state <= ST_IDLE;
                    end else if (keep) begin
                        fcnt  <= fcnt + 16'd1;
                        state <= is_last ? ST_IDLE : ST_CAPTURE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // empty is status only; frame control depends on full alone.
    ad_cap_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (fifo_wr_vld),
        .wr_dat (fifo_wr_dat),
        .full   (fifo_full),
        .empty  (fifo_empty_unused),
        .rd_vld (m_valid),
        .rd_rdy (m_ready),
        .rd_dat (fifo_rd_dat)
    );

    assign m_data = fifo_rd_dat[DATA_W-1:0];
    assign m_otr  = fifo_rd_dat[DATA_W + ENTRY_OTR_OFS];
    assign m_last = fifo_rd_dat[DATA_W + ENTRY_LAST_OFS];
    assign busy   = (state != ST_IDLE);
    assign ovf    = ovf_q;

endmodule
